// File: rtl/exec_controller.sv
// exec_controller: execution sequencer producing the core's single advance enable (run/slow/step/halt/break).
// Optional feature: define EXEC_CTRL_BREAKPOINT_EN to enable the PC breakpoint comparator and BREAK state.
module exec_controller #(
   parameter int TICK_DIV = 50_000_000,
   parameter int PC_W     = 6,
   parameter int CYC_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode_step,
   input  logic             slow_sw,
   input  logic             step_key_n,
   input  logic [2:0]       opcode,
   input  logic [PC_W-1:0]  pc,
   input  logic [PC_W-1:0]  bp_addr,
   input  logic             bp_arm,
   output logic             cpu_en,
   output logic [2:0]       state,
   output logic             halted,
   output logic [CYC_W-1:0] cycle_cnt
);
   typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, STEP = 3'd2, HALT = 3'd3, BREAK = 3'd4} state_t;
   localparam int PRE_W = $clog2(TICK_DIV);
   state_t cur, nxt;
   logic [PRE_W-1:0] pre;
   logic sync1, sync2, key_prev, step_pulse, tick, want, bp_hit;
   assign step_pulse = key_prev & ~sync2;
   assign tick = pre == PRE_W'(TICK_DIV - 1);
   assign want = slow_sw ? tick : 1'b1;
`ifdef EXEC_CTRL_BREAKPOINT_EN
   assign bp_hit = bp_arm && pc == bp_addr && want;
`else
   logic unused_bp;
   assign unused_bp = ^{bp_addr, bp_arm, pc};
   assign bp_hit = 1'b0;
`endif
   assign state = cur;
   assign halted = cur == HALT;
   // synchronise the raw step key and keep one extra stage for falling-edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         key_prev <= 1'b1;
      end else begin
         sync1 <= step_key_n;
         sync2 <= sync1;
         key_prev <= sync2;
      end
   end
   // prescaler runs only while free-running slowly, otherwise held at zero
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pre <= '0;
      else if (cur == RUN && slow_sw) pre <= tick ? '0 : pre + 1'b1;
      else pre <= '0;
   end
   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cur <= IDLE;
      else cur <= nxt;
   end
   // next-state and enable decode; halt beats breakpoint beats leaving run
   always_comb begin
      nxt = cur;
      cpu_en = 1'b0;
      case (cur)
         IDLE: nxt = !mode_step ? RUN : step_pulse ? STEP : IDLE;
         RUN: begin
            if (opcode == 3'b000) nxt = HALT;
            else if (bp_hit) nxt = BREAK;
            else if (mode_step) nxt = IDLE;
            else cpu_en = want;
         end
         STEP: begin
            nxt = opcode == 3'b000 ? HALT : IDLE;
            cpu_en = opcode != 3'b000;
         end
         HALT: nxt = HALT;
         BREAK: nxt = step_pulse ? STEP : BREAK;
         default: nxt = IDLE;
      endcase
   end
   // retired-instruction counter, saturating at all-ones
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cycle_cnt <= '0;
      else if (cpu_en && !(&cycle_cnt)) cycle_cnt <= cycle_cnt + 1'b1;
   end
endmodule
